// File: rtl/dma_addr_sequencer.sv
// Am2940-style DMA address/word-count sequencer: instruction-driven register file,
// address and word counters with reload bases, and an IDLE/RUN/DONE control FSM.
module dma_addr_sequencer #(
    parameter int AW = 8,
    parameter int WW = 8
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic [2:0]    instr,
    input  logic          instr_valid,
    input  logic [7:0]    data_in,
    output logic [7:0]    data_out,
    input  logic          xfer_req,
    output logic          xfer_ack,
    output logic [AW-1:0] addr_out,
    output logic          busy,
    output logic          done
);
    localparam logic [2:0] OP_WRCR   = 3'b000;
    localparam logic [2:0] OP_RDCR   = 3'b001;
    localparam logic [2:0] OP_RDWC   = 3'b010;
    localparam logic [2:0] OP_RDAC   = 3'b011;
    localparam logic [2:0] OP_REINIT = 3'b100;
    localparam logic [2:0] OP_LDADDR = 3'b101;
    localparam logic [2:0] OP_LDWC   = 3'b110;
    localparam logic [2:0] OP_ENCNT  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [2:0]    cr;
    logic [AW-1:0] addr, addr_base, addr_nxt, din_a;
    logic [WW-1:0] wc, wc_base, wc_nxt, din_w;
    logic          is_reinit, wr_ok;

    assign is_reinit = instr_valid && (instr == OP_REINIT);
    assign wr_ok     = (state != S_RUN);
    assign din_a     = AW'(data_in);
    assign din_w     = WW'(data_in);
    assign addr_out  = addr;

    // Completion test, shared by the ack step (post-step values) and ENCNT (current values).
    function automatic logic done_cond(input logic [1:0] m, input logic [WW-1:0] w,
                                       input logic [AW-1:0] a, input logic [WW-1:0] wb);
        case (m)
            2'b00:   return w == '0;
            2'b01:   return w == wb;
            2'b10:   return a[WW-1:0] == wb;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        addr_nxt = cr[2] ? addr - AW'(1) : addr + AW'(1);
        case (cr[1:0])
            2'b01:   wc_nxt = wc + WW'(1);
            2'b10:   wc_nxt = wc;
            default: wc_nxt = wc - WW'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (instr_valid && instr == OP_ENCNT)
                        state_nxt = done_cond(cr[1:0], wc, addr, wc_base) ? S_DONE : S_RUN;
            S_RUN: begin
                if (is_reinit)
                    state_nxt = S_IDLE;
                else if (xfer_ack && done_cond(cr[1:0], wc_nxt, addr_nxt, wc_base))
                    state_nxt = S_DONE;
            end
            S_DONE: if (is_reinit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == S_RUN);
        xfer_ack = xfer_req && (state == S_RUN) && !is_reinit;
    end

    // Counters only step in RUN and loads are refused in RUN, so the two never collide.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            cr        <= '0;
            addr      <= '0;
            addr_base <= '0;
            wc        <= '0;
            wc_base   <= '0;
            data_out  <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state_nxt == S_DONE);
            if (xfer_ack) begin
                addr <= addr_nxt;
                wc   <= wc_nxt;
            end
            if (instr_valid) begin
                case (instr)
                    OP_WRCR:   if (wr_ok) cr <= data_in[2:0];
                    OP_RDCR:   data_out <= {5'b0, cr};
                    OP_RDWC:   data_out <= 8'(wc);
                    OP_RDAC:   data_out <= 8'(addr);
                    OP_REINIT: begin
                        addr <= addr_base;
                        wc   <= (cr[1:0] == 2'b01) ? '0 : wc_base;
                    end
                    OP_LDADDR: if (wr_ok) begin
                        addr_base <= din_a;
                        addr      <= din_a;
                    end
                    OP_LDWC:   if (wr_ok) begin
                        wc_base <= din_w;
                        wc      <= (cr[1:0] == 2'b01) ? '0 : din_w;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dma_addr_sequencer.sv
// Scoreboard bench for dma_addr_sequencer: expected ack addresses are queued as
// each run is set up and popped as the DUT acknowledges transfers.
module tb_dma_addr_sequencer;
    localparam logic [2:0] WRCR = 3'b000, RDCR = 3'b001, RDWC = 3'b010, RDAC = 3'b011,
                           REINIT = 3'b100, LDADDR = 3'b101, LDWC = 3'b110, ENCNT = 3'b111;

    logic       clk = 1'b0;
    logic       res_n;
    logic [2:0] instr;
    logic       instr_valid;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       xfer_req;
    logic       xfer_ack;
    logic [7:0] addr_out;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    dma_addr_sequencer #(.AW(8), .WW(8)) dut (
        .clk(clk), .res_n(res_n), .instr(instr), .instr_valid(instr_valid),
        .data_in(data_in), .data_out(data_out), .xfer_req(xfer_req),
        .xfer_ack(xfer_ack), .addr_out(addr_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] c, input logic [7:0] d);
        instr_valid = 1'b1;
        instr       = c;
        data_in     = d;
        step();
        instr_valid = 1'b0;
    endtask

    // Holds xfer_req until every queued address has been acked; leaves the bench just past
    // the edge of the final ack with xfer_req dropped.
    task automatic run_acks(input string name, input int maxc);
        logic [7:0] a;
        int c = 0;
        xfer_req = 1'b1;
        while (exp_q.size() > 0 && c < maxc) begin
            @(negedge clk);
            if (xfer_ack) begin
                a = exp_q.pop_front();
                n_chk++;
                if (addr_out !== a) begin
                    n_fail++;
                    $display("FAIL %s ack addr: got %h expected %h", name, addr_out, a);
                end
            end
            c++;
            step();
        end
        xfer_req = 1'b0;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s ack timeout: got %0d missing acks expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        res_n = 1'b0; instr = '0; instr_valid = 1'b0; data_in = '0; xfer_req = 1'b0;
        repeat (3) step();
        n_chk++;
        if ({data_out, addr_out, busy, done, xfer_ack} !== 19'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got %h expected 0", {data_out, addr_out, busy, done, xfer_ack});
        end
        res_n = 1'b1;
        step();
        op(RDCR, 8'h00);
        n_chk++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset cr: got %h expected 00", data_out); end
    endtask

    task automatic test_mode00_up();
        op(WRCR, 8'h00); op(LDADDR, 8'h10); op(LDWC, 8'h03); op(ENCNT, 8'h00);
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL m00 busy rise: got %b expected 1", busy); end
        for (int i = 0; i < 3; i++) exp_q.push_back(8'(8'h10 + i));
        run_acks("m00", 20);
        n_chk++;
        if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL m00 busy/done: got %b expected 01", {busy, done}); end
        op(RDAC, 8'h00);
        n_chk++;
        if (data_out !== 8'h13) begin n_fail++; $display("FAIL m00 rdac: got %h expected 13", data_out); end
        op(RDWC, 8'h00);
        n_chk++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL m00 rdwc: got %h expected 00", data_out); end
        op(REINIT, 8'h00);
        n_chk++;
        if ({busy, done, addr_out} !== {2'b00, 8'h10}) begin
            n_fail++; $display("FAIL m00 reinit: got %h expected 010", {busy, done, addr_out});
        end
    endtask

    task automatic test_mode01_down();
        op(WRCR, 8'h05); op(LDADDR, 8'h00); op(LDWC, 8'h02); op(ENCNT, 8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        run_acks("m01", 20);
        n_chk++;
        if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL m01 busy/done: got %b expected 01", {busy, done}); end
        op(RDWC, 8'h00);
        n_chk++;
        if (data_out !== 8'h02) begin n_fail++; $display("FAIL m01 rdwc: got %h expected 02", data_out); end
        op(RDAC, 8'h00);
        n_chk++;
        if (data_out !== 8'hFE) begin n_fail++; $display("FAIL m01 rdac: got %h expected fe", data_out); end
        op(REINIT, 8'h00);
    endtask

    task automatic test_mode10();
        op(WRCR, 8'h02); op(LDADDR, 8'hFE); op(LDWC, 8'h01); op(ENCNT, 8'h00);
        exp_q.push_back(8'hFE); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        run_acks("m10", 20);
        n_chk++;
        if ({busy, done, addr_out} !== {2'b01, 8'h01}) begin
            n_fail++; $display("FAIL m10 end state: got %h expected 101", {busy, done, addr_out});
        end
        op(REINIT, 8'h00);
    endtask

    task automatic test_zero_length();
        op(WRCR, 8'h00); op(LDADDR, 8'h20); op(LDWC, 8'h00); op(ENCNT, 8'h00);
        n_chk++;
        if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL zlen busy/done: got %b expected 01", {busy, done}); end
        xfer_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if (xfer_ack !== 1'b0) begin n_fail++; $display("FAIL zlen ack: got %b expected 0", xfer_ack); end
            step();
        end
        xfer_req = 1'b0;
        op(WRCR, 8'h06); op(RDCR, 8'h00);
        n_chk++;
        if ({done, data_out} !== {1'b1, 8'h06}) begin
            n_fail++; $display("FAIL zlen wrcr in done: got %h expected 106", {done, data_out});
        end
        op(RDAC, 8'h00);
        n_chk++;
        if (data_out !== 8'h20) begin n_fail++; $display("FAIL zlen rdac: got %h expected 20", data_out); end
        op(REINIT, 8'h00);
    endtask

    task automatic test_mid_run();
        op(WRCR, 8'h00); op(LDADDR, 8'h40); op(LDWC, 8'h05); op(ENCNT, 8'h00);
        exp_q.push_back(8'h40); exp_q.push_back(8'h41);
        run_acks("mid", 20);
        xfer_req = 1'b1; instr_valid = 1'b1; instr = REINIT;
        @(negedge clk);
        n_chk++;
        if (xfer_ack !== 1'b0) begin n_fail++; $display("FAIL mid reinit ack: got %b expected 0", xfer_ack); end
        step();
        instr_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({xfer_ack, busy, done, addr_out} !== {3'b000, 8'h40}) begin
            n_fail++; $display("FAIL mid reinit state: got %h expected 040", {xfer_ack, busy, done, addr_out});
        end
        step();
        xfer_req = 1'b0;
        op(RDWC, 8'h00);
        n_chk++;
        if (data_out !== 8'h05) begin n_fail++; $display("FAIL mid reinit wc: got %h expected 05", data_out); end
        op(ENCNT, 8'h00);
        exp_q.push_back(8'h40);
        run_acks("mid2", 20);
        xfer_req = 1'b1; res_n = 1'b0;
        step();
        n_chk++;
        if ({data_out, addr_out, busy, done, xfer_ack} !== 19'b0) begin
            n_fail++; $display("FAIL mid reset outputs: got %h expected 0", {data_out, addr_out, busy, done, xfer_ack});
        end
        xfer_req = 1'b0; res_n = 1'b1;
        op(RDWC, 8'h00);
        n_chk++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL mid reset wc: got %h expected 00", data_out); end
    endtask

    task automatic test_mode11_wrap();
        op(WRCR, 8'h03); op(LDADDR, 8'h80); op(LDWC, 8'h40); op(ENCNT, 8'h00);
        for (int i = 0; i < 300; i++) exp_q.push_back(8'(8'h80 + i));
        run_acks("m11", 400);
        n_chk++;
        if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL m11 busy/done: got %b expected 10", {busy, done}); end
        op(WRCR, 8'h04); op(LDWC, 8'h99); op(LDADDR, 8'h11); op(ENCNT, 8'h00);
        op(RDCR, 8'h00);
        n_chk++;
        if (data_out !== 8'h03) begin n_fail++; $display("FAIL m11 cr ignored: got %h expected 03", data_out); end
        op(RDWC, 8'h00);
        n_chk++;
        if (data_out !== 8'h14) begin n_fail++; $display("FAIL m11 wc wrap: got %h expected 14", data_out); end
        op(RDAC, 8'h00);
        n_chk++;
        if (data_out !== 8'hAC) begin n_fail++; $display("FAIL m11 rdac: got %h expected ac", data_out); end
        op(REINIT, 8'h00);
        n_chk++;
        if ({busy, done, addr_out} !== {2'b00, 8'h80}) begin
            n_fail++; $display("FAIL m11 reinit: got %h expected 080", {busy, done, addr_out});
        end
    endtask

    initial begin
        test_reset();
        test_mode00_up();
        test_mode01_down();
        test_mode10();
        test_zero_length();
        test_mid_run();
        test_mode11_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
